// File: rtl/emif_calbus_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : emif_calbus_responder_if
// Purpose  : Calbus transaction signals between the IOSSM calibration master
//            and a calbus responder endpoint.
// Signals  : calbus_read        master -> slave  read strobe (1 cycle/txn)
//            calbus_write       master -> slave  write strobe (1 cycle/txn)
//            calbus_address     master -> slave  20-bit byte address
//            calbus_wdata       master -> slave  32-bit write data
//            calbus_rdata       slave  -> master 32-bit registered read data
//            calbus_rdata_valid slave  -> master 1-cycle read return pulse
// Revision : 1.0  initial release
// ============================================================================
interface emif_calbus_responder_if;
  logic        calbus_read;
  logic        calbus_write;
  logic [19:0] calbus_address;
  logic [31:0] calbus_wdata;
  logic [31:0] calbus_rdata;
  logic        calbus_rdata_valid;

  modport master (
    output calbus_read,
    output calbus_write,
    output calbus_address,
    output calbus_wdata,
    input  calbus_rdata,
    input  calbus_rdata_valid
  );

  modport slave (
    input  calbus_read,
    input  calbus_write,
    input  calbus_address,
    input  calbus_wdata,
    output calbus_rdata,
    output calbus_rdata_valid
  );
endinterface
`default_nettype wire

// File: rtl/emif_calbus_responder.sv
`default_nettype none
// ============================================================================
// Module   : emif_calbus_responder
// Purpose  : Target-side calbus endpoint. Holds the 128 x 32 sequencer
//            parameter table and a bank of RW control words, decodes calbus
//            reads/writes and returns read data after RD_LATENCY cycles.
// Ports    : calbus_clk           single clock
//            calbus_reset         synchronous, active-high reset
//            bus (slave modport)  read/write strobes, address, wdata,
//                                 rdata, rdata_valid
//            calbus_seq_param_tbl live parameter table (word k = [32k+31:32k])
//            csr_out              flattened RW control words
//            proto_err            sticky: read and write in the same cycle
// Revision : 1.0  initial release
// ============================================================================
module emif_calbus_responder #(
  parameter int            RD_LATENCY     = 2,     // 1..4
  parameter logic [4095:0] PARAM_TBL_INIT = '0,
  parameter int            CSR_WORDS      = 32     // 1..32
) (
  input  logic                      calbus_clk,
  input  logic                      calbus_reset,
  emif_calbus_responder_if.slave    bus,
  output logic [4095:0]             calbus_seq_param_tbl,
  output logic [32*CSR_WORDS-1:0]   csr_out,
  output logic                      proto_err
);

  localparam logic [19:0] c_addr_status = 20'h00400;
  localparam logic [19:0] c_addr_errcnt = 20'h00404;
  localparam logic [15:0] c_err_max     = 16'hFFFF;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [4095:0]           tbl_q,       tbl_d;
  logic [32*CSR_WORDS-1:0] csr_q,       csr_d;
  logic [15:0]             err_cnt_q,   err_cnt_d;
  logic                    proto_err_q, proto_err_d;

  // Read return pipeline; the last stage is the calbus_rdata register itself,
  // so it only loads when a valid read arrives and otherwise holds.
  logic [31:0] pipe_data_q [RD_LATENCY];
  logic [31:0] pipe_data_d [RD_LATENCY];
  logic        pipe_vld_q  [RD_LATENCY];
  logic        pipe_vld_d  [RD_LATENCY];

  // --------------------------------------------------------------------------
  // Address decode
  // --------------------------------------------------------------------------
  logic [19:0] w_addr;
  logic        w_aligned;
  logic        w_tbl_hit;
  logic [6:0]  w_tbl_idx;
  logic        w_csr_region;
  logic [4:0]  w_csr_idx;
  logic        w_csr_hit;
  logic        w_status_hit;
  logic        w_errcnt_hit;

  assign w_addr       = bus.calbus_address;
  assign w_aligned    = (w_addr[1:0] == 2'b00);
  assign w_tbl_hit    = w_aligned && (w_addr[19:9] == 11'd0);
  assign w_tbl_idx    = w_addr[8:2];
  // 0x200..0x27C shares upper bits [19:7] == 4
  assign w_csr_region = w_aligned && (w_addr[19:7] == 13'd4);
  assign w_csr_idx    = w_addr[6:2];
  assign w_csr_hit    = w_csr_region && (int'({27'd0, w_csr_idx}) < CSR_WORDS);
  assign w_status_hit = (w_addr == c_addr_status);
  assign w_errcnt_hit = (w_addr == c_addr_errcnt);

  // --------------------------------------------------------------------------
  // Read data mux: always sees pre-write state of the current cycle
  // --------------------------------------------------------------------------
  logic [31:0] w_rd_data;

  always_comb begin
    w_rd_data = '0;
    if (w_tbl_hit) begin
      w_rd_data = tbl_q[{w_tbl_idx, 5'd0} +: 32];
    end else if (w_csr_hit) begin
      for (int k = 0; k < CSR_WORDS; k++) begin
        if (w_csr_idx == 5'(k)) begin
          w_rd_data = csr_q[k*32 +: 32];
        end
      end
    end else if (w_status_hit) begin
      w_rd_data = {15'd0, proto_err_q, err_cnt_q};
    end else if (w_errcnt_hit) begin
      w_rd_data = {16'd0, err_cnt_q};
    end
  end

  // --------------------------------------------------------------------------
  // Write path, error accounting
  // --------------------------------------------------------------------------
  logic w_rd;
  logic w_wr;
  logic w_rd_accept;
  logic w_wr_ok;
  logic w_rd_ok;
  logic w_err_event;
  logic w_err_clear;

  assign w_rd = bus.calbus_read;
  assign w_wr = bus.calbus_write;

  // A read colliding with a write is dropped; the write still goes ahead.
  assign w_rd_accept = w_rd && !w_wr;
  assign w_wr_ok     = w_tbl_hit || w_csr_hit || w_errcnt_hit;
  assign w_rd_ok     = w_tbl_hit || w_csr_hit || w_status_hit || w_errcnt_hit;

  // At most one error per cycle: a collision counts once even if the write
  // target is also unmapped.
  assign w_err_event = w_wr ? (w_rd || !w_wr_ok) : (w_rd && !w_rd_ok);
  assign w_err_clear = w_wr && w_errcnt_hit;

  always_comb begin
    tbl_d = tbl_q;
    csr_d = csr_q;
    if (w_wr && w_tbl_hit) begin
      tbl_d[{w_tbl_idx, 5'd0} +: 32] = bus.calbus_wdata;
    end
    if (w_wr && w_csr_hit) begin
      for (int k = 0; k < CSR_WORDS; k++) begin
        if (w_csr_idx == 5'(k)) begin
          csr_d[k*32 +: 32] = bus.calbus_wdata;
        end
      end
    end
  end

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (w_err_clear) begin
      // clear and error in one cycle leaves a count of exactly one
      err_cnt_d = {15'd0, w_err_event};
    end else if (w_err_event && (err_cnt_q != c_err_max)) begin
      err_cnt_d = err_cnt_q + 16'd1;
    end
  end

  assign proto_err_d = proto_err_q || (w_rd && w_wr);

  // --------------------------------------------------------------------------
  // Read return pipeline
  // --------------------------------------------------------------------------
  always_comb begin
    pipe_vld_d[0]  = w_rd_accept;
    pipe_data_d[0] = w_rd_accept ? w_rd_data : pipe_data_q[0];
    for (int k = 1; k < RD_LATENCY; k++) begin
      pipe_vld_d[k]  = pipe_vld_q[k-1];
      pipe_data_d[k] = pipe_vld_q[k-1] ? pipe_data_q[k-1] : pipe_data_q[k];
    end
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge calbus_clk) begin
    if (calbus_reset) begin
      tbl_q       <= PARAM_TBL_INIT;
      csr_q       <= '0;
      err_cnt_q   <= '0;
      proto_err_q <= 1'b0;
      for (int k = 0; k < RD_LATENCY; k++) begin
        pipe_vld_q[k]  <= 1'b0;
        pipe_data_q[k] <= '0;
      end
    end else begin
      tbl_q       <= tbl_d;
      csr_q       <= csr_d;
      err_cnt_q   <= err_cnt_d;
      proto_err_q <= proto_err_d;
      for (int k = 0; k < RD_LATENCY; k++) begin
        pipe_vld_q[k]  <= pipe_vld_d[k];
        pipe_data_q[k] <= pipe_data_d[k];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.calbus_rdata       = pipe_data_q[RD_LATENCY-1];
  assign bus.calbus_rdata_valid = pipe_vld_q[RD_LATENCY-1];
  assign calbus_seq_param_tbl   = tbl_q;
  assign csr_out                = csr_q;
  assign proto_err              = proto_err_q;

endmodule
`default_nettype wire

// File: tb/tb_emif_calbus_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_emif_calbus_responder
// Purpose  : Self-checking bench for emif_calbus_responder: directed scenarios
//            with literal expectations plus randomized traffic compared every
//            cycle against an address-map level reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_emif_calbus_responder;

  localparam int RD_LAT = 2;
  localparam int CSR_W  = 32;

  function automatic logic [4095:0] make_init();
    logic [4095:0] r;
    r = '0;
    for (int k = 0; k < 128; k++) r[k*32 +: 32] = 32'hA500_0000 | 32'(k);
    return r;
  endfunction

  localparam logic [4095:0] TB_INIT = make_init();

  logic                  clk;
  logic                  calbus_reset;
  logic [4095:0]         tbl_out;
  logic [32*CSR_W-1:0]   csr_out_w;
  logic                  proto_err_w;

  emif_calbus_responder_if bus_if ();

  emif_calbus_responder #(
    .RD_LATENCY     (RD_LAT),
    .PARAM_TBL_INIT (TB_INIT),
    .CSR_WORDS      (CSR_W)
  ) dut (
    .calbus_clk           (clk),
    .calbus_reset         (calbus_reset),
    .bus                  (bus_if.slave),
    .calbus_seq_param_tbl (tbl_out),
    .csr_out              (csr_out_w),
    .proto_err            (proto_err_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct {
    int          due;
    logic [31:0] data;
  } rd_t;

  logic [31:0] m_tbl [128];
  logic [31:0] m_csr [CSR_W];
  logic [15:0] m_err;
  bit          m_proto;
  logic [31:0] m_rdata;
  rd_t         m_q [$];
  logic [31:0] seen [$];

  int cyc;
  bit checking;
  int n_checks;
  int n_pass;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic void model_read(input logic [19:0] a, output logic [31:0] d, output bit ok);
    int idx;
    d  = '0;
    ok = 1'b0;
    if (a[1:0] != 2'b00) return;
    if (a < 20'h200) begin
      d = m_tbl[a[8:2]]; ok = 1'b1;
    end else if (a < 20'h280) begin
      idx = int'((a - 20'h200) >> 2);
      if (idx < CSR_W) begin d = m_csr[idx]; ok = 1'b1; end
    end else if (a == 20'h400) begin
      d = {15'd0, m_proto, m_err}; ok = 1'b1;
    end else if (a == 20'h404) begin
      d = {16'd0, m_err}; ok = 1'b1;
    end
  endfunction

  task automatic model_apply(input bit rst, input bit rd, input bit wr,
                             input logic [19:0] a, input logic [31:0] d);
    bit          err;
    bit          clr;
    bit          ok;
    logic [31:0] rv;
    int          idx;
    rd_t         e;
    if (rst) begin
      for (int k = 0; k < 128; k++) m_tbl[k] = TB_INIT[k*32 +: 32];
      for (int k = 0; k < CSR_W; k++) m_csr[k] = '0;
      m_err   = '0;
      m_proto = 1'b0;
      m_rdata = '0;
      m_q.delete();
      return;
    end
    err = 1'b0;
    clr = 1'b0;
    if (rd && !wr) begin
      model_read(a, rv, ok);
      e.due  = cyc + RD_LAT;
      e.data = rv;
      m_q.push_back(e);
      if (!ok) err = 1'b1;
    end
    if (wr) begin
      if (rd) begin err = 1'b1; m_proto = 1'b1; end
      ok = 1'b0;
      if (a[1:0] == 2'b00) begin
        if (a < 20'h200) begin
          m_tbl[a[8:2]] = d; ok = 1'b1;
        end else if (a < 20'h280) begin
          idx = int'((a - 20'h200) >> 2);
          if (idx < CSR_W) begin m_csr[idx] = d; ok = 1'b1; end
        end else if (a == 20'h404) begin
          clr = 1'b1; ok = 1'b1;
        end
      end
      if (!ok) err = 1'b1;
    end
    if (clr) m_err = err ? 16'd1 : 16'd0;
    else if (err && m_err != 16'hFFFF) m_err = m_err + 16'd1;
  endtask

  task automatic compare_outputs();
    bit exp_v;
    int w;
    exp_v = (m_q.size() > 0) && (m_q[0].due == cyc);
    if (exp_v) begin
      m_rdata = m_q[0].data;
      void'(m_q.pop_front());
    end
    chk("rdata_valid", {31'd0, bus_if.calbus_rdata_valid}, {31'd0, exp_v});
    chk("rdata", bus_if.calbus_rdata, m_rdata);
    if (bus_if.calbus_rdata_valid === 1'b1) seen.push_back(bus_if.calbus_rdata);
    chk("proto_err", {31'd0, proto_err_w}, {31'd0, m_proto});
    w = 0;
    for (int k = 127; k >= 0; k--) if (tbl_out[k*32 +: 32] !== m_tbl[k]) w = k;
    chk("seq_param_tbl_word", tbl_out[w*32 +: 32], m_tbl[w]);
    w = 0;
    for (int k = CSR_W-1; k >= 0; k--) if (csr_out_w[k*32 +: 32] !== m_csr[k]) w = k;
    chk("csr_out_word", csr_out_w[w*32 +: 32], m_csr[w]);
  endtask

  task automatic step(input bit rst, input bit rd, input bit wr,
                      input logic [19:0] a, input logic [31:0] d);
    @(negedge clk);
    if (checking) compare_outputs();
    calbus_reset          = rst;
    bus_if.calbus_read    = rd;
    bus_if.calbus_write   = wr;
    bus_if.calbus_address = a;
    bus_if.calbus_wdata   = d;
    model_apply(rst, rd, wr, a, d);
    if (rst) checking = 1'b1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 20'h0, 32'h0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] tmp;
    logic [19:0] a;
    bit          rst;
    bit          rd;
    bit          wr;
    int          op;
    int          sel;

    cyc = 0; checking = 1'b0; n_checks = 0; n_pass = 0;
    m_err = '0; m_proto = 1'b0; m_rdata = '0;
    calbus_reset = 1'b1;
    bus_if.calbus_read = 1'b0; bus_if.calbus_write = 1'b0;
    bus_if.calbus_address = '0; bus_if.calbus_wdata = '0;

    // T1: reset, read whole table
    step(1'b1, 1'b0, 1'b0, 20'h0, 32'h0);
    seen.delete();
    for (int k = 0; k < 128; k++) step(1'b0, 1'b1, 1'b0, 20'(k*4), 32'h0);
    idle(RD_LAT);
    chk("t1_count", 32'(seen.size()), 32'd128);
    chk("t1_word5", seen[5], 32'hA500_0005);
    chk("t1_word127", seen[127], 32'hA500_007F);
    chk("t1_tbl_w0", tbl_out[31:0], 32'hA500_0000);

    // T2: write then read same address on the next cycle
    seen.delete();
    step(1'b0, 1'b0, 1'b1, 20'h00010, 32'hDEAD_BEEF);
    step(1'b0, 1'b1, 1'b0, 20'h00010, 32'h0);
    idle(RD_LAT);
    chk("t2_raw", seen[0], 32'hDEAD_BEEF);
    chk("t2_tbl_w4", tbl_out[159:128], 32'hDEAD_BEEF);

    // T3: back-to-back CSR reads
    for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 1'b1, 20'(20'h200 + k*4), 32'(k+1));
    seen.delete();
    for (int k = 0; k < 4; k++) step(1'b0, 1'b1, 1'b0, 20'(20'h200 + k*4), 32'h0);
    idle(RD_LAT);
    chk("t3_count", 32'(seen.size()), 32'd4);
    for (int k = 0; k < 4; k++) begin
      tmp = seen[k];
      chk("t3_csr_read", tmp, 32'(k+1));
    end

    // T4: unmapped accesses and ERR_CNT
    step(1'b1, 1'b0, 1'b0, 20'h0, 32'h0);
    seen.delete();
    step(1'b0, 1'b1, 1'b0, 20'h00002, 32'h0);
    step(1'b0, 1'b0, 1'b1, 20'h00800, 32'h1234);
    step(1'b0, 1'b1, 1'b0, 20'h00280, 32'h0);
    idle(RD_LAT);
    chk("t4_count", 32'(seen.size()), 32'd2);
    chk("t4_unmapped0", seen[0], 32'h0);
    chk("t4_unmapped1", seen[1], 32'h0);
    seen.delete();
    step(1'b0, 1'b1, 1'b0, 20'h00404, 32'h0);
    idle(RD_LAT);
    chk("t4_errcnt3", seen[0], 32'd3);
    seen.delete();
    step(1'b0, 1'b0, 1'b1, 20'h00404, 32'hFFFF_FFFF);
    step(1'b0, 1'b1, 1'b0, 20'h00404, 32'h0);
    idle(RD_LAT);
    chk("t4_errcnt_cleared", seen[0], 32'd0);

    // T5: read and write collide
    seen.delete();
    step(1'b0, 1'b1, 1'b1, 20'h00200, 32'h55);
    idle(RD_LAT);
    chk("t5_no_valid", 32'(seen.size()), 32'd0);
    chk("t5_csr0", csr_out_w[31:0], 32'h55);
    chk("t5_proto_err", {31'd0, proto_err_w}, 32'd1);
    step(1'b0, 1'b1, 1'b0, 20'h00400, 32'h0);
    idle(RD_LAT);
    tmp = seen[0];
    chk("t5_status_b16", {31'd0, tmp[16]}, 32'd1);
    chk("t5_status_cnt", {16'd0, tmp[15:0]}, 32'd1);

    // T6: reset flushes an in-flight read
    step(1'b0, 1'b0, 1'b1, 20'h00010, 32'h1111_2222);
    seen.delete();
    step(1'b0, 1'b1, 1'b0, 20'h00010, 32'h0);
    step(1'b1, 1'b0, 1'b0, 20'h0, 32'h0);
    idle(RD_LAT + 1);
    chk("t6_no_valid", 32'(seen.size()), 32'd0);
    chk("t6_rdata0", bus_if.calbus_rdata, 32'h0);
    chk("t6_tbl_w4", tbl_out[159:128], 32'hA500_0004);
    chk("t6_proto0", {31'd0, proto_err_w}, 32'd0);

    // Randomized traffic, model-checked every cycle
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      op  = $urandom_range(0, 9);
      rd  = !rst && ((op <= 3) || (op == 8));
      wr  = !rst && ((op >= 4) && (op <= 8));
      sel = $urandom_range(0, 9);
      case (sel)
        0, 1:    a = {11'd0, 3'd0, 4'($urandom_range(0, 15)), 2'b00};
        2, 3:    a = {11'd0, 7'($urandom_range(0, 127)), 2'b00};
        4, 5:    a = 20'(20'h200 + 4 * $urandom_range(0, 31));
        6:       a = 20'h00400;
        7:       a = 20'h00404;
        default: a = 20'($urandom);
      endcase
      step(rst, rd, wr, a, $urandom);
    end
    idle(RD_LAT + 2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
